// File: rtl/icache_pkg.sv
// Shared types and constants for the direct-mapped instruction cache.
package icache_pkg;

    localparam int DATA_W  = 32;
    localparam int BE_W    = 4;
    localparam int BURST_W = 8;

    localparam logic READ_ENABLE  = 1'b1;
    localparam logic READ_DISABLE = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_MISS_REQ  = 2'd1,
        ST_MISS_FILL = 2'd2,
        ST_RESP      = 2'd3
    } state_e;

endpackage

// File: rtl/icache_if.sv
// CPU word-read port and memory burst-read port of the instruction cache.
// Handshake: the CPU read is accepted in a cycle with o_p_waitrequest=0; the memory
// command is taken in a cycle with i_m_waitrequest=0; *_readdata_valid qualifies data
// for exactly one cycle and has no back-pressure.
interface icache_if #(
    parameter int ADDR_W = 25
) ();
    logic [ADDR_W-1:0]                 i_p_addr;
    logic                              i_p_read;
    logic                              i_p_write;
    logic [icache_pkg::BE_W-1:0]       i_p_byte_en;
    logic [icache_pkg::DATA_W-1:0]     i_p_writedata;
    logic [icache_pkg::DATA_W-1:0]     o_p_readdata;
    logic                              o_p_readdata_valid;
    logic                              o_p_waitrequest;
    logic [ADDR_W-1:0]                 o_m_addr;
    logic                              o_m_read;
    logic [icache_pkg::BURST_W-1:0]    o_m_burstcount;
    logic [icache_pkg::DATA_W-1:0]     i_m_readdata;
    logic                              i_m_readdata_valid;
    logic                              i_m_waitrequest;

    modport slave (
        input  i_p_addr, i_p_read, i_p_write, i_p_byte_en, i_p_writedata,
        output o_p_readdata, o_p_readdata_valid, o_p_waitrequest,
        output o_m_addr, o_m_read, o_m_burstcount,
        input  i_m_readdata, i_m_readdata_valid, i_m_waitrequest
    );

    modport master (
        output i_p_addr, i_p_read, i_p_write, i_p_byte_en, i_p_writedata,
        input  o_p_readdata, o_p_readdata_valid, o_p_waitrequest,
        input  o_m_addr, o_m_read, o_m_burstcount,
        output i_m_readdata, i_m_readdata_valid, i_m_waitrequest
    );
endinterface

// File: rtl/icache_data_ram.sv
// Cache data store: synchronous-read RAM with independent read and write addresses,
// written so it can map onto an FPGA block RAM.
module icache_data_ram #(
    parameter int DEPTH = 256,
    parameter int AW    = 8,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);
    logic [DW-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_o <= mem_q[raddr_i];
    end
endmodule

// File: rtl/icache.sv
// Read-only direct-mapped instruction cache: one-cycle hits, one burst refill per miss,
// and a whole-cache invalidate that is deferred while a refill is in flight.
module icache
    import icache_pkg::*;
#(
    parameter int SET_NUM    = 64,
    parameter int LINE_WORDS = 4,
    parameter int ADDR_W     = 25
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   i_flush,
    icache_if.slave bus,
    output state_e o_dbg_state
);
    localparam int OFF_W  = $clog2(LINE_WORDS);
    localparam int IDX_W  = $clog2(SET_NUM);
    localparam int TAG_W  = ADDR_W - OFF_W - IDX_W;
    localparam int RAM_AW = IDX_W + OFF_W;

    logic [OFF_W-1:0] req_off, lat_off;
    logic [IDX_W-1:0] req_idx, lat_idx;
    logic [TAG_W-1:0] req_tag, lat_tag;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [OFF_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   word_q, word_d;
    logic                hit_q, hit_d;
    logic                flush_pend_q, flush_pend_d;
    logic [SET_NUM-1:0]  valid_q;
    logic [TAG_W-1:0]    tag_q [SET_NUM];

    logic                lookup_hit;
    logic                ram_we;
    logic                fill_done;
    logic                fill_valid;
    logic                clear_all;
    logic [DATA_W-1:0]   ram_rdata;
    logic                unused_ok;

    assign {req_tag, req_idx, req_off} = bus.i_p_addr;
    assign {lat_tag, lat_idx, lat_off} = addr_q;

    // A flush in the lookup cycle forces a miss, even though the valid bits clear only at the edge.
    assign lookup_hit = valid_q[req_idx] && (tag_q[req_idx] == req_tag) && !i_flush;
    assign fill_valid = !(flush_pend_q || i_flush);

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        cnt_d        = cnt_q;
        word_d       = word_q;
        hit_d        = 1'b0;
        flush_pend_d = flush_pend_q;
        ram_we       = 1'b0;
        fill_done    = 1'b0;
        clear_all    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                clear_all = i_flush;
                if (bus.i_p_read) begin
                    addr_d = bus.i_p_addr;
                    if (lookup_hit) begin
                        hit_d = 1'b1;
                    end else begin
                        state_d = ST_MISS_REQ;
                    end
                end
            end
            ST_MISS_REQ: begin
                flush_pend_d = flush_pend_q || i_flush;
                if (!bus.i_m_waitrequest) begin
                    cnt_d   = '0;
                    state_d = ST_MISS_FILL;
                end
            end
            ST_MISS_FILL: begin
                flush_pend_d = flush_pend_q || i_flush;
                if (bus.i_m_readdata_valid) begin
                    ram_we = 1'b1;
                    cnt_d  = cnt_q + OFF_W'(1);
                    if (cnt_q == lat_off) begin
                        word_d = bus.i_m_readdata;
                    end
                    if (cnt_q == OFF_W'(LINE_WORDS - 1)) begin
                        fill_done = 1'b1;
                        state_d   = ST_RESP;
                    end
                end
            end
            ST_RESP: begin
                clear_all    = flush_pend_q || i_flush;
                flush_pend_d = 1'b0;
                state_d      = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            cnt_q        <= '0;
            word_q       <= '0;
            hit_q        <= 1'b0;
            flush_pend_q <= 1'b0;
            valid_q      <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            cnt_q        <= cnt_d;
            word_q       <= word_d;
            hit_q        <= hit_d;
            flush_pend_q <= flush_pend_d;
            if (clear_all) begin
                valid_q <= '0;
            end else if (fill_done && fill_valid) begin
                valid_q[lat_idx] <= 1'b1;
            end
        end
    end

    // Tags need no reset: a line is only trusted once its valid bit is set.
    always_ff @(posedge clk) begin
        if (fill_done) begin
            tag_q[lat_idx] <= lat_tag;
        end
    end

    icache_data_ram #(
        .DEPTH (SET_NUM * LINE_WORDS),
        .AW    (RAM_AW),
        .DW    (DATA_W)
    ) u_data_ram (
        .clk     (clk),
        .we_i    (ram_we),
        .waddr_i ({lat_idx, cnt_q}),
        .wdata_i (bus.i_m_readdata),
        .raddr_i ({req_idx, req_off}),
        .rdata_o (ram_rdata)
    );

    assign bus.o_p_waitrequest    = (state_q != ST_IDLE);
    assign bus.o_p_readdata_valid = hit_q || (state_q == ST_RESP);
    assign bus.o_p_readdata       = hit_q ? ram_rdata :
                                    ((state_q == ST_RESP) ? word_q : '0);
    assign bus.o_m_read           = (state_q == ST_MISS_REQ) ? READ_ENABLE : READ_DISABLE;
    assign bus.o_m_addr           = (state_q == ST_MISS_REQ) ?
                                    {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}} : '0;
    assign bus.o_m_burstcount     = BURST_W'(LINE_WORDS);
    assign o_dbg_state            = state_q;

    // CPU writes are accepted and discarded.
    assign unused_ok = ^{bus.i_p_write, bus.i_p_byte_en, bus.i_p_writedata};
endmodule
